// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: MODE encodings.
package usr_pkg;
    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'b001;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'b011;
    localparam logic [MODE_W-1:0] MODE_ROR  = 3'b100;
    localparam logic [MODE_W-1:0] MODE_ROL  = 3'b101;
endpackage

// File: rtl/universal_shift_register_if.sv
// Control/data bundle of the universal shift register; master drives controls, slave is the register.
interface universal_shift_register_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
);
    import usr_pkg::*;

    logic                PRE;
    logic                EN;
    logic [MODE_W-1:0]   MODE;
    logic [WIDTH-1:0]    D;
    logic                SI_R;
    logic                SI_L;
    logic [WIDTH-1:0]    Q;
    logic [WIDTH-1:0]    Q_N;
    logic                SO_R;
    logic                SO_L;
    logic [CNT_W-1:0]    CNT;
    logic                DONE;

    modport master (
        output PRE, EN, MODE, D, SI_R, SI_L,
        input  Q, Q_N, SO_R, SO_L, CNT, DONE
    );

    modport slave (
        input  PRE, EN, MODE, D, SI_R, SI_L,
        output Q, Q_N, SO_R, SO_L, CNT, DONE
    );
endinterface

// File: rtl/usr_shift_counter.sv
// Saturating count of shifts since the last load/preset, with a one-cycle DONE pulse on reaching WIDTH.
module usr_shift_counter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             i_clear,
    input  logic             i_step,
    input  logic             i_enable,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_done
);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(WIDTH);

    logic [CNT_W-1:0] r_cnt;
    logic             r_done;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (i_clear) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (i_enable && i_step) begin
            if (r_cnt != FULL) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Only the WIDTH-1 -> WIDTH transition pulses; saturated shifts stay quiet.
            r_done <= (r_cnt == FULL - 1'b1);
        end else begin
            r_done <= 1'b0;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_done = r_done;
endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit load/shift/rotate register with async clear and sync preset.
// Rotate modes exist only when USR_ROTATE_EN is defined; otherwise 100/101 decode as hold.
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                         CLK,
    input  logic                         CLR,
    universal_shift_register_if.slave    bus
);
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;
    logic             w_step;
    logic             w_clear;
    logic [CNT_W-1:0] w_cnt;
    logic             w_done;

    always_comb begin
        w_q_next = r_q;
        w_step   = 1'b0;
        case (bus.MODE)
            MODE_SHR: begin
                w_q_next = {bus.SI_R, r_q[WIDTH-1:1]};
                w_step   = 1'b1;
            end
            MODE_SHL: begin
                w_q_next = {r_q[WIDTH-2:0], bus.SI_L};
                w_step   = 1'b1;
            end
            MODE_LOAD: w_q_next = bus.D;
`ifdef USR_ROTATE_EN
            MODE_ROR: begin
                w_q_next = {r_q[0], r_q[WIDTH-1:1]};
                w_step   = 1'b1;
            end
            MODE_ROL: begin
                w_q_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                w_step   = 1'b1;
            end
`endif
            default: w_q_next = r_q;
        endcase
    end

    // Preset beats EN; a load only restarts the count when it actually executes.
    assign w_clear = !bus.PRE || (bus.EN && (bus.MODE == MODE_LOAD));

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_q <= '0;
        end else if (!bus.PRE) begin
            r_q <= '1;
        end else if (bus.EN) begin
            r_q <= w_q_next;
        end
    end

    usr_shift_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_cnt (
        .CLK      (CLK),
        .CLR      (CLR),
        .i_clear  (w_clear),
        .i_step   (w_step),
        .i_enable (bus.EN),
        .o_cnt    (w_cnt),
        .o_done   (w_done)
    );

    assign bus.Q    = r_q;
    assign bus.Q_N  = ~r_q;
    assign bus.SO_R = r_q[0];
    assign bus.SO_L = r_q[WIDTH-1];
    assign bus.CNT  = w_cnt;
    assign bus.DONE = w_done;
endmodule

// File: tb/tb_universal_shift_register.sv
// Directed self-checking bench for universal_shift_register at WIDTH=8.
module tb_universal_shift_register;
    import usr_pkg::*;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic CLK;
    logic CLR;
    int   n_vec;
    int   n_err;

    universal_shift_register_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    universal_shift_register #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One rising edge; inputs may be changed and outputs sampled 1 ns after it.
    task automatic tick(input logic [2:0] mode);
        bus.MODE = mode;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        CLR = 1'b0;
        bus.PRE = 1'b1; bus.EN = 1'b1; bus.MODE = MODE_HOLD;
        bus.D = '0; bus.SI_R = 1'b0; bus.SI_L = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        n_vec++;
        if (bus.Q !== 8'h00 || bus.Q_N !== 8'hFF || bus.CNT !== 4'd0 || bus.DONE !== 1'b0) begin
            n_err++;
            $display("FAIL reset: Q=%h Q_N=%h CNT=%0d DONE=%b, want 00 FF 0 0", bus.Q, bus.Q_N, bus.CNT, bus.DONE);
        end
        CLR = 1'b1;
    endtask

    task automatic test_load_shr();
        logic [7:0] exp_so;
        exp_so = 8'b1001_0110;   // SO_R sequence 0,1,1,0,1,0,0,1 read LSB first
        bus.D = 8'h96;
        tick(MODE_LOAD);
        n_vec++;
        if (bus.Q !== 8'h96 || bus.CNT !== 4'd0) begin
            n_err++;
            $display("FAIL load96: Q=%h CNT=%0d, want 96 0", bus.Q, bus.CNT);
        end
        bus.SI_R = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (bus.SO_R !== exp_so[i]) begin
                n_err++;
                $display("FAIL shr_so[%0d]: SO_R=%b, want %b", i, bus.SO_R, exp_so[i]);
            end
            tick(MODE_SHR);
            n_vec++;
            if (bus.CNT !== 4'(i + 1) || bus.DONE !== (i == 7)) begin
                n_err++;
                $display("FAIL shr_cnt[%0d]: CNT=%0d DONE=%b, want %0d %b", i, bus.CNT, bus.DONE, i + 1, (i == 7));
            end
        end
        n_vec++;
        if (bus.Q !== 8'h00 || bus.Q_N !== 8'hFF) begin
            n_err++;
            $display("FAIL shr_final: Q=%h Q_N=%h, want 00 FF", bus.Q, bus.Q_N);
        end
    endtask

    task automatic test_saturate();
        bus.SI_R = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(MODE_SHR);
            n_vec++;
            if (bus.CNT !== 4'd8 || bus.DONE !== 1'b0) begin
                n_err++;
                $display("FAIL saturate[%0d]: CNT=%0d DONE=%b, want 8 0", i, bus.CNT, bus.DONE);
            end
        end
        n_vec++;
        if (bus.Q !== 8'hE0 || bus.SO_L !== 1'b1) begin
            n_err++;
            $display("FAIL saturate_q: Q=%h SO_L=%b, want E0 1", bus.Q, bus.SO_L);
        end
    endtask

    task automatic test_clr_async();
        bus.D = 8'hA5;
        tick(MODE_LOAD);
        tick(MODE_HOLD);
        n_vec++;
        if (bus.Q !== 8'hA5) begin
            n_err++;
            $display("FAIL clr_pre: Q=%h, want A5", bus.Q);
        end
        #2 CLR = 1'b0;
        #1;
        n_vec++;
        if (bus.Q !== 8'h00 || bus.Q_N !== 8'hFF || bus.CNT !== 4'd0 || bus.DONE !== 1'b0) begin
            n_err++;
            $display("FAIL clr_async: Q=%h Q_N=%h CNT=%0d DONE=%b, want 00 FF 0 0", bus.Q, bus.Q_N, bus.CNT, bus.DONE);
        end
        #1 CLR = 1'b1;
        @(posedge CLK); #1;
        bus.D = 8'h3C;
        tick(MODE_LOAD);
        bus.SI_R = 1'b1;
        tick(MODE_SHR);
        tick(MODE_SHR);
        n_vec++;
        if (bus.Q !== 8'hCF || bus.CNT !== 4'd2) begin
            n_err++;
            $display("FAIL clr_midshift_pre: Q=%h CNT=%0d, want CF 2", bus.Q, bus.CNT);
        end
        #2 CLR = 1'b0;
        #1 CLR = 1'b1;
        tick(MODE_SHR);
        n_vec++;
        if (bus.Q !== 8'h80 || bus.CNT !== 4'd1) begin
            n_err++;
            $display("FAIL clr_midshift: Q=%h CNT=%0d, want 80 1", bus.Q, bus.CNT);
        end
    endtask

    task automatic test_shl();
        bus.D = 8'h01;
        tick(MODE_LOAD);
        bus.SI_L = 1'b1;
        repeat (3) tick(MODE_SHL);
        n_vec++;
        if (bus.Q !== 8'h0F || bus.CNT !== 4'd3 || bus.DONE !== 1'b0) begin
            n_err++;
            $display("FAIL shl: Q=%h CNT=%0d DONE=%b, want 0F 3 0", bus.Q, bus.CNT, bus.DONE);
        end
        bus.SI_L = 1'b0;
    endtask

    task automatic test_pre_en();
        bus.D = 8'h5A;
        tick(MODE_LOAD);
        bus.SI_R = 1'b0;
        tick(MODE_SHR);
        bus.PRE = 1'b0;
        bus.D = 8'h00;
        tick(MODE_LOAD);
        bus.PRE = 1'b1;
        n_vec++;
        if (bus.Q !== 8'hFF || bus.Q_N !== 8'h00 || bus.CNT !== 4'd0) begin
            n_err++;
            $display("FAIL preset: Q=%h Q_N=%h CNT=%0d, want FF 00 0", bus.Q, bus.Q_N, bus.CNT);
        end
        tick(MODE_SHR);
        bus.EN = 1'b0;
        tick(MODE_SHR);
        tick(MODE_LOAD);
        n_vec++;
        if (bus.Q !== 8'h7F || bus.CNT !== 4'd1 || bus.DONE !== 1'b0) begin
            n_err++;
            $display("FAIL en_low: Q=%h CNT=%0d DONE=%b, want 7F 1 0", bus.Q, bus.CNT, bus.DONE);
        end
        bus.EN = 1'b1;
        tick(MODE_HOLD);
        tick(3'b110);
        tick(3'b111);
        n_vec++;
        if (bus.Q !== 8'h7F || bus.CNT !== 4'd1 || bus.DONE !== 1'b0) begin
            n_err++;
            $display("FAIL hold_modes: Q=%h CNT=%0d DONE=%b, want 7F 1 0", bus.Q, bus.CNT, bus.DONE);
        end
    endtask

    task automatic test_rotate();
        bus.D = 8'h81;
        tick(MODE_LOAD);
        tick(MODE_ROR);
`ifdef USR_ROTATE_EN
        n_vec++;
        if (bus.Q !== 8'hC0 || bus.CNT !== 4'd1) begin
            n_err++;
            $display("FAIL ror1: Q=%h CNT=%0d, want C0 1", bus.Q, bus.CNT);
        end
        for (int i = 2; i <= 8; i++) begin
            tick(MODE_ROR);
            n_vec++;
            if (bus.DONE !== (i == 8)) begin
                n_err++;
                $display("FAIL ror_done[%0d]: DONE=%b, want %b", i, bus.DONE, (i == 8));
            end
        end
        n_vec++;
        if (bus.Q !== 8'h81 || bus.CNT !== 4'd8) begin
            n_err++;
            $display("FAIL ror8: Q=%h CNT=%0d, want 81 8", bus.Q, bus.CNT);
        end
        tick(MODE_LOAD);
        tick(MODE_ROL);
        n_vec++;
        if (bus.Q !== 8'h03 || bus.CNT !== 4'd1) begin
            n_err++;
            $display("FAIL rol1: Q=%h CNT=%0d, want 03 1", bus.Q, bus.CNT);
        end
`else
        n_vec++;
        if (bus.Q !== 8'h81 || bus.CNT !== 4'd0 || bus.DONE !== 1'b0) begin
            n_err++;
            $display("FAIL ror_off: Q=%h CNT=%0d DONE=%b, want 81 0 0", bus.Q, bus.CNT, bus.DONE);
        end
        tick(MODE_ROL);
        n_vec++;
        if (bus.Q !== 8'h81 || bus.CNT !== 4'd0) begin
            n_err++;
            $display("FAIL rol_off: Q=%h CNT=%0d, want 81 0", bus.Q, bus.CNT);
        end
`endif
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_load_shr();
        test_saturate();
        test_clr_async();
        test_shl();
        test_pre_en();
        test_rotate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
